// File: rtl/axi_lite_arb_pkg.sv
// Shared types and helpers for the AXI4-Lite round-robin arbiter.
// Holds the default AXI4-Lite structs, the FSM state type and the round-robin pick function.
package axi_lite_arb_pkg;

  localparam int unsigned MaxSlvPorts = 16;
  localparam int unsigned IdxW        = $clog2(MaxSlvPorts);

  typedef logic [IdxW-1:0] idx_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [2:0]  prot;
  } axi_lite_ax_t;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
  } axi_lite_w_t;

  typedef struct packed {
    logic [1:0] resp;
  } axi_lite_b_t;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } axi_lite_r_t;

  typedef struct packed {
    axi_lite_ax_t aw;
    logic         aw_valid;
    axi_lite_w_t  w;
    logic         w_valid;
    logic         b_ready;
    axi_lite_ax_t ar;
    logic         ar_valid;
    logic         r_ready;
  } axi_lite_req_t;

  typedef struct packed {
    logic        aw_ready;
    logic        w_ready;
    axi_lite_b_t b;
    logic        b_valid;
    logic        ar_ready;
    axi_lite_r_t r;
    logic        r_valid;
  } axi_lite_resp_t;

  // First requesting index at or after ptr, wrapping at num; returns ptr if nothing requests.
  function automatic idx_t rr_pick(input logic [MaxSlvPorts-1:0] req, input idx_t ptr,
                                   input int unsigned num);
    idx_t        pick;
    logic        found;
    logic [31:0] cand;
    pick  = ptr;
    found = 1'b0;
    for (int unsigned k = 0; k < MaxSlvPorts; k++) begin
      cand = (32'(ptr) + k) % num;
      if (!found && (k < num) && req[cand[IdxW-1:0]]) begin
        found = 1'b1;
        pick  = idx_t'(cand);
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/axi_lite_arb_idx_fifo.sv
// Small non-fall-through FIFO of port indices used to route B/R responses back to requesters.
module axi_lite_arb_idx_fifo
  import axi_lite_arb_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic push_i,
  input  idx_t data_i,
  input  logic pop_i,
  output idx_t data_o,
  output logic full_o,
  output logic empty_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);
  localparam logic [CntW-1:0] FullCnt = CntW'(Depth);

  idx_t            r_mem [Depth];
  logic [PtrW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CntW-1:0] r_cnt;
  logic            w_push, w_pop;

  // A pop frees the slot this cycle, so a push at full is still accepted.
  assign w_push  = push_i && (!full_o || pop_i);
  assign w_pop   = pop_i && !empty_o;
  assign full_o  = (r_cnt == FullCnt);
  assign empty_o = (r_cnt == '0);
  assign data_o  = r_mem[r_rd_ptr];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_push) r_wr_ptr <= (r_wr_ptr == LastPtr) ? '0 : r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= (r_rd_ptr == LastPtr) ? '0 : r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_cnt <= r_cnt + 1'b1;
      else if (!w_push && w_pop) r_cnt <= r_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= data_i;
  end

endmodule

// File: rtl/axi_lite_rr_arbiter.sv
// Round-robin arbiter sharing one AXI4-Lite master port between NumSlvPorts requesters.
// Define AXI_LITE_ARB_PERF_EN to add per-port AW+AR grant counters on grant_cnt_o.
module axi_lite_rr_arbiter
  import axi_lite_arb_pkg::*;
#(
  parameter int unsigned NumSlvPorts = 2,
  parameter int unsigned MaxTxns     = 4,
  parameter type         lite_req_t  = axi_lite_req_t,
  parameter type         lite_resp_t = axi_lite_resp_t
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  lite_req_t  slv_reqs_i  [NumSlvPorts],
  output lite_resp_t slv_resps_o [NumSlvPorts],
  output lite_req_t  mst_req_o,
  input  lite_resp_t mst_resp_i
`ifdef AXI_LITE_ARB_PERF_EN
  ,
  output logic [NumSlvPorts-1:0][31:0] grant_cnt_o
`endif
);

  arb_state_e r_wr_state, r_rd_state;
  idx_t       r_wr_idx, r_wr_ptr, r_rd_idx, r_rd_ptr;
  logic       r_aw_done, r_w_done;

  logic [MaxSlvPorts-1:0] w_aw_req, w_ar_req;
  idx_t w_wr_pick, w_rd_pick, w_b_head, w_r_head;
  logic w_wr_grant, w_rd_grant, w_aw_hs, w_w_hs, w_ar_hs, w_wr_done;
  logic w_b_full, w_b_empty, w_b_pop, w_r_full, w_r_empty, w_r_pop;

  always_comb begin
    w_aw_req = '0;
    w_ar_req = '0;
    for (int unsigned i = 0; i < NumSlvPorts; i++) begin
      w_aw_req[i] = slv_reqs_i[i].aw_valid;
      w_ar_req[i] = slv_reqs_i[i].ar_valid;
    end
  end

  assign w_wr_pick  = rr_pick(w_aw_req, r_wr_ptr, NumSlvPorts);
  assign w_rd_pick  = rr_pick(w_ar_req, r_rd_ptr, NumSlvPorts);
  assign w_wr_grant = (r_wr_state == IDLE) && (|w_aw_req) && !w_b_full;
  assign w_rd_grant = (r_rd_state == IDLE) && (|w_ar_req) && !w_r_full;

  always_comb begin
    mst_req_o = '0;
    for (int unsigned i = 0; i < NumSlvPorts; i++) begin
      slv_resps_o[i]   = '0;
      slv_resps_o[i].b = mst_resp_i.b;
      slv_resps_o[i].r = mst_resp_i.r;
      if ((r_wr_state == BUSY) && (r_wr_idx == idx_t'(i))) begin
        mst_req_o.aw             = slv_reqs_i[i].aw;
        mst_req_o.aw_valid       = slv_reqs_i[i].aw_valid && !r_aw_done;
        mst_req_o.w              = slv_reqs_i[i].w;
        mst_req_o.w_valid        = slv_reqs_i[i].w_valid && !r_w_done;
        slv_resps_o[i].aw_ready  = mst_resp_i.aw_ready && !r_aw_done;
        slv_resps_o[i].w_ready   = mst_resp_i.w_ready && !r_w_done;
      end
      if ((r_rd_state == BUSY) && (r_rd_idx == idx_t'(i))) begin
        mst_req_o.ar             = slv_reqs_i[i].ar;
        mst_req_o.ar_valid       = slv_reqs_i[i].ar_valid;
        slv_resps_o[i].ar_ready  = mst_resp_i.ar_ready;
      end
      if (!w_b_empty && (w_b_head == idx_t'(i))) begin
        slv_resps_o[i].b_valid   = mst_resp_i.b_valid;
        mst_req_o.b_ready        = slv_reqs_i[i].b_ready;
      end
      if (!w_r_empty && (w_r_head == idx_t'(i))) begin
        slv_resps_o[i].r_valid   = mst_resp_i.r_valid;
        mst_req_o.r_ready        = slv_reqs_i[i].r_ready;
      end
    end
  end

  assign w_aw_hs   = mst_req_o.aw_valid && mst_resp_i.aw_ready;
  assign w_w_hs    = mst_req_o.w_valid && mst_resp_i.w_ready;
  assign w_ar_hs   = mst_req_o.ar_valid && mst_resp_i.ar_ready;
  assign w_wr_done = (r_wr_state == BUSY) && (r_aw_done || w_aw_hs) && (r_w_done || w_w_hs);
  assign w_b_pop   = mst_resp_i.b_valid && mst_req_o.b_ready;
  assign w_r_pop   = mst_resp_i.r_valid && mst_req_o.r_ready;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_state <= IDLE;
      r_wr_idx   <= '0;
      r_wr_ptr   <= '0;
      r_aw_done  <= 1'b0;
      r_w_done   <= 1'b0;
    end else if (r_wr_state == IDLE) begin
      if (w_wr_grant) begin
        r_wr_state <= BUSY;
        r_wr_idx   <= w_wr_pick;
        r_aw_done  <= 1'b0;
        r_w_done   <= 1'b0;
      end
    end else if (w_wr_done) begin
      r_wr_state <= IDLE;
      r_wr_ptr   <= (r_wr_idx == idx_t'(NumSlvPorts - 1)) ? '0 : r_wr_idx + 1'b1;
      r_aw_done  <= 1'b0;
      r_w_done   <= 1'b0;
    end else begin
      r_aw_done  <= r_aw_done || w_aw_hs;
      r_w_done   <= r_w_done || w_w_hs;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rd_state <= IDLE;
      r_rd_idx   <= '0;
      r_rd_ptr   <= '0;
    end else if (r_rd_state == IDLE) begin
      if (w_rd_grant) begin
        r_rd_state <= BUSY;
        r_rd_idx   <= w_rd_pick;
      end
    end else if (w_ar_hs) begin
      r_rd_state <= IDLE;
      r_rd_ptr   <= (r_rd_idx == idx_t'(NumSlvPorts - 1)) ? '0 : r_rd_idx + 1'b1;
    end
  end

  axi_lite_arb_idx_fifo #(
    .Depth (MaxTxns)
  ) u_b_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (w_wr_done),
    .data_i  (r_wr_idx),
    .pop_i   (w_b_pop),
    .data_o  (w_b_head),
    .full_o  (w_b_full),
    .empty_o (w_b_empty)
  );

  axi_lite_arb_idx_fifo #(
    .Depth (MaxTxns)
  ) u_r_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (w_ar_hs),
    .data_i  (r_rd_idx),
    .pop_i   (w_r_pop),
    .data_o  (w_r_head),
    .full_o  (w_r_full),
    .empty_o (w_r_empty)
  );

`ifdef AXI_LITE_ARB_PERF_EN
  logic [NumSlvPorts-1:0][31:0] r_grant_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_grant_cnt <= '0;
    end else begin
      for (int unsigned i = 0; i < NumSlvPorts; i++) begin
        r_grant_cnt[i] <= r_grant_cnt[i]
                        + 32'(w_wr_grant && (w_wr_pick == idx_t'(i)))
                        + 32'(w_rd_grant && (w_rd_pick == idx_t'(i)));
      end
    end
  end

  assign grant_cnt_o = r_grant_cnt;
`endif

endmodule
